dm_responder: RTL and testbench

DM_RESPONDER -- requirements
Module: dm_responder

---
 rtl/dm_pkg.sv | 21 ++
 rtl/dm_responder_if.sv | 29 ++
 rtl/dm_lane_align.sv | 57 +++++
 rtl/dm_responder.sv | 157 +++++++++++++++
 tb/tb_dm_responder.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/dm_pkg.sv
// Shared types and defaults for the data-memory responder.
// Holds access-width encodings, FSM states and parameter defaults.
package dm_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2,
        RSVD = 2'd3
    } width_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int DEF_DEPTH_WORDS = 256;
    localparam int DEF_WAIT_CYCLES = 2;

endpackage

// File: rtl/dm_responder_if.sv
// Request/response handshake bundle between initiator and responder.
// master = initiator (drives req_*, resp_ready); slave = responder.
interface dm_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_width;
    logic        req_sext;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata,
        output req_width, req_sext, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata,
        input  req_width, req_sext, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/dm_lane_align.sv
// Little-endian byte-lane handling for stores and loads.
// In: addrLo, width, sext, wdata, oldWord. Out: byteEn, mergedWord, loadData.
module dm_lane_align
    import dm_pkg::*;
(
    input  logic [1:0]  addrLo,
    input  width_e      width,
    input  logic        sext,
    input  logic [31:0] wdata,
    input  logic [31:0] oldWord,
    output logic [3:0]  byteEn,
    output logic [31:0] mergedWord,
    output logic [31:0] loadData
);

    logic [7:0]  selByte;
    logic [15:0] selHalf;
    logic [31:0] wLanes;

    assign selByte = oldWord[{addrLo, 3'b000} +: 8];
    assign selHalf = addrLo[1] ? oldWord[31:16] : oldWord[15:0];

    always_comb begin
        byteEn   = '0;
        wLanes   = '0;
        loadData = '0;
        unique case (width)
            BYTE: begin
                byteEn   = 4'b0001 << addrLo;
                wLanes   = {4{wdata[7:0]}};
                loadData = {{24{sext & selByte[7]}}, selByte};
            end
            HALF: begin
                byteEn   = addrLo[1] ? 4'b1100 : 4'b0011;
                wLanes   = {2{wdata[15:0]}};
                loadData = {{16{sext & selHalf[15]}}, selHalf};
            end
            WORD: begin
                byteEn   = 4'b1111;
                wLanes   = wdata;
                loadData = oldWord;
            end
            RSVD: begin
                byteEn   = '0;
            end
        endcase
    end

    // Replicated store data lands only on enabled lanes.
    always_comb begin
        mergedWord = oldWord;
        for (int i = 0; i < 4; i++) begin
            if (byteEn[i]) mergedWord[8*i +: 8] = wLanes[8*i +: 8];
        end
    end

endmodule

// File: rtl/dm_responder.sv
// Single-outstanding data-memory responder with programmable wait states.
// Ports: clk, reset (async, active-low), bus (dm_responder_if.slave).
module dm_responder
    import dm_pkg::*;
#(
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    dm_responder_if.slave bus
);

    localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    state_e        state;
    logic [CW-1:0] cnt;
    logic          wrQ;
    logic [31:0]   addrQ;
    logic [31:0]   wdataQ;
    width_e        widthQ;
    logic          sextQ;
    logic          respValid;
    logic [31:0]   respRdata;
    logic          respErr;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          idle;
    logic          curWr;
    logic [31:0]   curAddr;
    logic [31:0]   curWdata;
    width_e        curWidth;
    logic          curSext;
    logic          misaligned;
    logic          accErr;
    logic          goResp;
    logic [IW-1:0] idx;
    logic [31:0]   oldWord;
    logic [3:0]    byteEn;
    logic [31:0]   mergedWord;
    logic [31:0]   loadData;
    logic [31:0]   respData;

    assign idle = (state == IDLE);

    // With zero wait states the access resolves on the acceptance
    // edge itself, so it must see the live bus rather than the capture.
    assign curWr    = idle ? bus.req_wr    : wrQ;
    assign curAddr  = idle ? bus.req_addr  : addrQ;
    assign curWdata = idle ? bus.req_wdata : wdataQ;
    assign curWidth = idle ? width_e'(bus.req_width) : widthQ;
    assign curSext  = idle ? bus.req_sext  : sextQ;

    always_comb begin
        misaligned = 1'b0;
        unique case (curWidth)
            BYTE: misaligned = 1'b0;
            HALF: misaligned = curAddr[0];
            WORD: misaligned = |curAddr[1:0];
            RSVD: misaligned = 1'b1;
        endcase
    end

    assign accErr = misaligned
                  | ({2'b00, curAddr[31:2]} >= 32'(DEPTH_WORDS));

    assign goResp = reset
                  & (((state == WAIT) && (cnt == '0))
                  | (idle && bus.req_valid && (WAIT_CYCLES == 0)));

    assign idx     = curAddr[IW+1:2];
    assign oldWord = mem[idx];

    dm_lane_align uAlign (
        .addrLo     (curAddr[1:0]),
        .width      (curWidth),
        .sext       (curSext),
        .wdata      (curWdata),
        .oldWord    (oldWord),
        .byteEn     (byteEn),
        .mergedWord (mergedWord),
        .loadData   (loadData)
    );

    assign respData = (curWr | accErr) ? '0 : loadData;

    always_ff @(posedge clk) begin
        if (goResp && curWr && !accErr) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEn[i]) mem[idx][8*i +: 8] <= mergedWord[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            wrQ       <= 1'b0;
            addrQ     <= '0;
            wdataQ    <= '0;
            widthQ    <= BYTE;
            sextQ     <= 1'b0;
            respValid <= 1'b0;
            respRdata <= '0;
            respErr   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        wrQ    <= bus.req_wr;
                        addrQ  <= bus.req_addr;
                        wdataQ <= bus.req_wdata;
                        widthQ <= width_e'(bus.req_width);
                        sextQ  <= bus.req_sext;
                        if (WAIT_CYCLES == 0) begin
                            state     <= RESP;
                            respValid <= 1'b1;
                            respRdata <= respData;
                            respErr   <= accErr;
                        end else begin
                            state <= WAIT;
                            cnt   <= CW'(WAIT_CYCLES - 1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state     <= RESP;
                        respValid <= 1'b1;
                        respRdata <= respData;
                        respErr   <= accErr;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state     <= IDLE;
                        respValid <= 1'b0;
                        respRdata <= '0;
                        respErr   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = idle;
    assign bus.resp_valid = respValid;
    assign bus.resp_rdata = respRdata;
    assign bus.resp_err   = respErr;

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder: directed accesses, stall, reset abort.
// Expected responses are queued at acceptance and checked by a monitor.
module tb_dm_responder;
    import dm_pkg::*;

    localparam int WAITC = 2;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   totalCount = 0;
    int   passCount = 0;
    int   firstCyc = 0;
    logic prevValid = 1'b0;
    exp_t sbq[$];

    dm_responder_if bus();

    dm_responder #(
        .DEPTH_WORDS (256),
        .WAIT_CYCLES (WAITC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        totalCount++;
        if (act === exp) passCount++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Monitor: rising resp_valid marks latency; handshake pops the queue.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            if (bus.resp_valid && !prevValid) firstCyc = cyc;
            if (bus.resp_valid && bus.resp_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("rdata", bus.resp_rdata, e.rdata);
                    chk("err", {31'b0, bus.resp_err}, {31'b0, e.err});
                    chk("latency", 32'(firstCyc - e.acc), 32'(WAITC));
                end
            end
        end
        prevValid = bus.resp_valid;
    end

    task automatic drive(input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] width,
                         input logic sext);
        bus.req_valid = 1'b1;
        bus.req_wr    = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_width = width;
        bus.req_sext  = sext;
    endtask

    // Junk on the bus while not idle must be ignored.
    task automatic junk();
        bus.req_valid = 1'b0;
        bus.req_wr    = 1'b1;
        bus.req_addr  = 32'h10;
        bus.req_wdata = 32'h0;
        bus.req_width = WORD;
        bus.req_sext  = 1'b1;
    endtask

    task automatic doReq(input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] width,
                         input logic sext, input logic [31:0] expData,
                         input logic expErr, input int stall);
        int n;
        exp_t e;
        @(negedge clk);
        n = 0;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_wait", {31'b0, bus.req_ready}, 32'd1);
        drive(wr, addr, wdata, width, sext);
        bus.resp_ready = (stall == 0);
        @(posedge clk);
        #1;
        junk();
        e.rdata = expData;
        e.err   = expErr;
        e.acc   = cyc;
        sbq.push_back(e);
        if (stall > 0) begin
            @(negedge clk);
            n = 0;
            while (!bus.resp_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            for (int i = 0; i < stall; i++) begin
                chk("stall_valid", {31'b0, bus.resp_valid}, 32'd1);
                chk("stall_rdata", bus.resp_rdata, expData);
                chk("stall_err", {31'b0, bus.resp_err}, {31'b0, expErr});
                chk("stall_req_ready", {31'b0, bus.req_ready}, 32'd0);
                drive(1'b1, 32'h10, 32'h0, WORD, 1'b0);
                @(negedge clk);
            end
            junk();
            bus.resp_ready = 1'b1;
        end
        n = 0;
        while (sbq.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(sbq.size()), 32'd0);
        sbq.delete();
    endtask

    initial begin
        junk();
        bus.resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        chk("rst_rdata", bus.resp_rdata, 32'd0);
        chk("rst_err", {31'b0, bus.resp_err}, 32'd0);
        chk("rst_cnt", 32'(dut.cnt), 32'd0);
        reset = 1'b1;

        doReq(1, 32'h10, 32'hDEADBEEF, WORD, 0, 32'h0, 0, 0);
        doReq(0, 32'h10, 32'h0, WORD, 0, 32'hDEADBEEF, 0, 0);
        doReq(0, 32'h13, 32'h0, BYTE, 1, 32'hFFFFFFDE, 0, 0);
        doReq(0, 32'h13, 32'h0, BYTE, 0, 32'h000000DE, 0, 0);
        doReq(0, 32'h10, 32'h0, HALF, 1, 32'hFFFFBEEF, 0, 0);
        doReq(0, 32'h12, 32'h0, HALF, 0, 32'h0000DEAD, 0, 0);
        doReq(0, 32'h10, 32'h0, BYTE, 1, 32'hFFFFFFEF, 0, 0);
        doReq(1, 32'h11, 32'h55, BYTE, 0, 32'h0, 0, 0);
        doReq(0, 32'h10, 32'h0, WORD, 0, 32'hDEAD55EF, 0, 0);

        doReq(0, 32'h11, 32'h0, HALF, 0, 32'h0, 1, 0);
        doReq(1, 32'h12, 32'h11111111, WORD, 0, 32'h0, 1, 0);
        doReq(0, 32'h10, 32'h0, RSVD, 0, 32'h0, 1, 0);
        doReq(1, 32'h10, 32'h22222222, RSVD, 0, 32'h0, 1, 0);
        doReq(0, 32'h400, 32'h0, WORD, 0, 32'h0, 1, 0);
        doReq(1, 32'h400, 32'h33333333, WORD, 0, 32'h0, 1, 0);
        doReq(1, 32'h13, 32'h44444444, HALF, 0, 32'h0, 1, 0);
        doReq(0, 32'h10, 32'h0, WORD, 0, 32'hDEAD55EF, 0, 0);

        doReq(1, 32'h12, 32'hFFFFA5A5, HALF, 0, 32'h0, 0, 0);
        doReq(0, 32'h10, 32'h0, WORD, 0, 32'hA5A555EF, 0, 0);
        doReq(1, 32'h3FC, 32'h0BADF00D, WORD, 0, 32'h0, 0, 0);
        doReq(0, 32'h3FC, 32'h0, WORD, 0, 32'h0BADF00D, 0, 0);
        doReq(0, 32'h3FF, 32'h0, BYTE, 1, 32'h0000000B, 0, 0);

        doReq(0, 32'h10, 32'h0, WORD, 0, 32'hA5A555EF, 0, 5);
        doReq(0, 32'h10, 32'h0, WORD, 0, 32'hA5A555EF, 0, 0);

        doReq(1, 32'h20, 32'hCAFEF00D, WORD, 0, 32'h0, 0, 0);
        @(negedge clk);
        drive(1'b1, 32'h20, 32'h12345678, WORD, 1'b0);
        @(posedge clk);
        #1;
        junk();
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("abort_req_ready", {31'b0, bus.req_ready}, 32'd1);
        chk("abort_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        chk("abort_rdata", bus.resp_rdata, 32'd0);
        chk("abort_err", {31'b0, bus.resp_err}, 32'd0);
        repeat (2) @(negedge clk);
        sbq.delete();
        reset = 1'b1;
        doReq(0, 32'h20, 32'h0, WORD, 0, 32'hCAFEF00D, 0, 0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
